window_buffer: RTL and testbench

3x3 pixel window register for the Sobel edge-detection datapath. It loads 8-bit pixels one at a time from the memory read path into a 3x3 window, and slides the window one column or row in any of four directions. Each completed read or shift is reported with a one-cycle done pulse. The window feeds the Sobel gradient stage directly.

---
 rtl/window_buffer.sv | 151 +++++++++++++++
 tb/tb_window_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/window_buffer.sv
// 3x3 pixel window for the Sobel datapath: serial pixel fill plus one-step slides in four directions.
// Optional build macro WINDOW_BUFFER_ZERO_FILL_EN clears the vacated line on a shift.
module window_buffer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_read,
    input  logic       start_shift,
    input  logic [1:0] shift_direc,
    input  logic [7:0] data_r,
    output logic       read_done,
    output logic       shift_done,
    output logic [7:0] windowBuffer [0:8]
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned N_PIX  = 9;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [1:0] {IDLE, DONE_R, DONE_S} state_t;
    typedef enum logic [2:0] {SEQ_FULL, SEQ_LEFT, SEQ_RIGHT, SEQ_DOWN, SEQ_UP} seq_t;

    state_t             state_q, state_d;
    seq_t               seq_q, seq_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PIX_W-1:0]   win_q [0:N_PIX-1];
    logic [PIX_W-1:0]   win_d [0:N_PIX-1];
    logic               read_done_q, read_done_d;
    logic               shift_done_q, shift_done_d;
    logic [IDX_W-1:0]   slot_c;

    // Map the fill pointer onto a window slot for the active sequence.
    always_comb begin
        slot_c = 4'd6;
        unique case (seq_q)
            SEQ_FULL: begin
                unique case (idx_q)
                    4'd0:    slot_c = 4'd6;
                    4'd1:    slot_c = 4'd7;
                    4'd2:    slot_c = 4'd8;
                    4'd3:    slot_c = 4'd3;
                    4'd4:    slot_c = 4'd4;
                    4'd5:    slot_c = 4'd5;
                    4'd6:    slot_c = 4'd0;
                    4'd7:    slot_c = 4'd1;
                    default: slot_c = 4'd2;
                endcase
            end
            SEQ_LEFT:  slot_c = 4'(idx_q * 4'd3 + 4'd2);
            SEQ_RIGHT: slot_c = 4'(idx_q * 4'd3);
            SEQ_DOWN:  slot_c = idx_q;
            SEQ_UP:    slot_c = 4'(idx_q + 4'd6);
            default:   slot_c = 4'd6;
        endcase
    end

    // Next-state, window update and pointer sequencing.
    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        idx_d        = idx_q;
        win_d        = win_q;
        read_done_d  = 1'b0;
        shift_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_shift) begin
                    state_d      = DONE_S;
                    shift_done_d = 1'b1;
                    idx_d        = '0;
                    unique case (shift_direc)
                        2'b01: begin
                            seq_d = SEQ_LEFT;
                            for (int r = 0; r < 3; r++) begin
                                for (int c = 0; c < 2; c++) win_d[r*3+c] = win_q[r*3+c+1];
`ifdef WINDOW_BUFFER_ZERO_FILL_EN
                                win_d[r*3+2] = '0;
`endif
                            end
                        end
                        2'b10: begin
                            seq_d = SEQ_RIGHT;
                            for (int r = 0; r < 3; r++) begin
                                for (int c = 1; c < 3; c++) win_d[r*3+c] = win_q[r*3+c-1];
`ifdef WINDOW_BUFFER_ZERO_FILL_EN
                                win_d[r*3] = '0;
`endif
                            end
                        end
                        2'b11: begin
                            seq_d = SEQ_DOWN;
                            for (int c = 0; c < 3; c++) begin
                                for (int r = 1; r < 3; r++) win_d[r*3+c] = win_q[(r-1)*3+c];
`ifdef WINDOW_BUFFER_ZERO_FILL_EN
                                win_d[c] = '0;
`endif
                            end
                        end
                        default: begin
                            seq_d = SEQ_UP;
                            for (int c = 0; c < 3; c++) begin
                                for (int r = 0; r < 2; r++) win_d[r*3+c] = win_q[(r+1)*3+c];
`ifdef WINDOW_BUFFER_ZERO_FILL_EN
                                win_d[6+c] = '0;
`endif
                            end
                        end
                    endcase
                end else if (start_read) begin
                    state_d        = DONE_R;
                    read_done_d    = 1'b1;
                    win_d[slot_c]  = data_r;
                    if (seq_q == SEQ_FULL) begin
                        idx_d = (idx_q == 4'd8) ? '0 : 4'(idx_q + 4'd1);
                    end else if (idx_q == 4'd2) begin
                        seq_d = SEQ_FULL;
                        idx_d = '0;
                    end else begin
                        idx_d = 4'(idx_q + 4'd1);
                    end
                end
            end
            DONE_R:  state_d = IDLE;
            DONE_S:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q      <= IDLE;
            seq_q        <= SEQ_FULL;
            idx_q        <= '0;
            win_q        <= '{default: '0};
            read_done_q  <= 1'b0;
            shift_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            win_q        <= win_d;
            read_done_q  <= read_done_d;
            shift_done_q <= shift_done_d;
        end
    end

    assign read_done    = read_done_q;
    assign shift_done   = shift_done_q;
    assign windowBuffer = win_q;

endmodule

// File: tb/tb_window_buffer.sv
// Directed self-checking bench for window_buffer; follows WINDOW_BUFFER_ZERO_FILL_EN for vacated-line expectations.
module tb_window_buffer;

    logic       clk = 1'b0;
    logic       n_rst, start_read, start_shift;
    logic [1:0] shift_direc;
    logic [7:0] data_r;
    logic       read_done, shift_done;
    logic [7:0] win   [0:8];
    logic [7:0] exp_w [0:8];
    logic [7:0] pix   [0:8];
    logic [7:0] v;

    int checks   = 0;
    int failures = 0;

`ifdef WINDOW_BUFFER_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    always #5 clk = ~clk;

    window_buffer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start_read   (start_read),
        .start_shift  (start_shift),
        .shift_direc  (shift_direc),
        .data_r       (data_r),
        .read_done    (read_done),
        .shift_done   (shift_done),
        .windowBuffer (win)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_win(input string tag);
        for (int i = 0; i < 9; i++) chk($sformatf("%s[%0d]", tag, i), win[i], exp_w[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] d);
        data_r     = d;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        chk("read_done_pulse", 8'(read_done), 8'd1);
        chk("shift_done_quiet", 8'(shift_done), 8'd0);
        tick();
        chk("read_done_clear", 8'(read_done), 8'd0);
    endtask

    task automatic do_shift(input logic [1:0] d);
        shift_direc = d;
        start_shift = 1'b1;
        tick();
        start_shift = 1'b0;
        chk("shift_done_pulse", 8'(shift_done), 8'd1);
        chk("read_done_quiet", 8'(read_done), 8'd0);
        tick();
        chk("shift_done_clear", 8'(shift_done), 8'd0);
    endtask

    // Nine reads from the start of the full-load order: every row becomes {a,b,c}.
    task automatic load_rows(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int i = 0; i < 9; i++) do_read((i % 3 == 0) ? a : (i % 3 == 1) ? b : c);
    endtask

    initial begin
        pix         = '{8'd6, 8'd7, 8'd8, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
        n_rst       = 1'b1;
        start_read  = 1'b0;
        start_shift = 1'b0;
        shift_direc = 2'b00;
        data_r      = 8'h00;
        tick();
        tick();
        exp_w = '{default: 8'h00};
        chk_win("reset_win");
        chk("reset_read_done", 8'(read_done), 8'd0);
        chk("reset_shift_done", 8'(shift_done), 8'd0);
        n_rst = 1'b0;

        // Held start_read: one accept every two cycles.
        start_read = 1'b1;
        for (int i = 0; i < 9; i++) begin
            data_r = pix[i];
            tick();
            chk($sformatf("held_read_pulse%0d", i), 8'(read_done), 8'd1);
            tick();
            chk($sformatf("held_read_gap%0d", i), 8'(read_done), 8'd0);
        end
        start_read = 1'b0;
        exp_w = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        chk_win("full_load");

        // Left shift, then refill of column 2.
        load_rows(8'd0, 8'd1, 8'd3);
        do_shift(2'b01);
        v = ZERO_FILL ? 8'd0 : 8'd3;
        exp_w = '{8'd1, 8'd3, v, 8'd1, 8'd3, v, 8'd1, 8'd3, v};
        chk_win("shift_left");
        for (int i = 0; i < 3; i++) do_read(8'd9);
        exp_w = '{8'd1, 8'd3, 8'd9, 8'd1, 8'd3, 8'd9, 8'd1, 8'd3, 8'd9};
        chk_win("refill_left");

        // Right then down.
        load_rows(8'd3, 8'd0, 8'd0);
        do_shift(2'b10);
        v = ZERO_FILL ? 8'd0 : 8'd3;
        exp_w = '{v, 8'd3, 8'd0, v, 8'd3, 8'd0, v, 8'd3, 8'd0};
        chk_win("shift_right");
        do_shift(2'b11);
        if (ZERO_FILL) exp_w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd3, 8'd0};
        else           exp_w = '{v, 8'd3, 8'd0, v, 8'd3, 8'd0, v, 8'd3, 8'd0};
        chk_win("shift_down");

        // Partial refill interrupted by an up shift.
        do_read(8'd5);
        chk("refill_down_slot0", win[0], 8'd5);
        do_shift(2'b00);
        do_read(8'd7);
        if (ZERO_FILL) exp_w = '{8'd0, 8'd3, 8'd0, 8'd0, 8'd3, 8'd0, 8'd7, 8'd0, 8'd0};
        else           exp_w = '{v, 8'd3, 8'd0, v, 8'd3, 8'd0, 8'd7, 8'd3, 8'd0};
        chk_win("shift_up_refill");

        // Reset in the middle of a load.
        for (int i = 0; i < 4; i++) do_read(8'(8'h20 + i));
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        exp_w = '{default: 8'h00};
        chk_win("midload_reset");
        chk("midload_reset_read_done", 8'(read_done), 8'd0);
        do_read(8'd4);
        exp_w[6] = 8'd4;
        chk_win("post_reset_read");

        // Simultaneous requests: shift wins, read dropped.
        data_r      = 8'hAA;
        shift_direc = 2'b11;
        start_read  = 1'b1;
        start_shift = 1'b1;
        tick();
        start_read  = 1'b0;
        start_shift = 1'b0;
        chk("both_shift_done", 8'(shift_done), 8'd1);
        chk("both_read_done", 8'(read_done), 8'd0);
        exp_w = '{default: 8'h00};
        chk_win("both_win");
        tick();
        do_read(8'h55);
        exp_w[0] = 8'h55;
        chk_win("both_next_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
